fb_seq_div: RTL and testbench

Multi-cycle restoring divider that inverts the team's combinational add/sub datapath. It divides a WIDTH-bit dividend by a WIDTH-bit divisor using one trial subtraction per cycle. It sits beside the 4-bit add/sub block as the sequential arithmetic unit. A start/busy/done handshake connects it to a controller.

---
 rtl/fb_div_pkg.sv | 23 ++
 rtl/fb_addsub_unit.sv | 27 ++
 rtl/fb_seq_div.sv | 161 ++++++++++++++++
 tb/tb_fb_seq_div.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_div_pkg.sv
// Shared definitions for the fb_seq_div sequential divider:
// FSM state encoding, default operand width and counter sizing.
package fb_div_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Plain-vector aliases of the state encoding, used by the FSM register.
  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] CALC = S_CALC;
  localparam logic [1:0] DONE = S_DONE;

  // Width of a down-counter that must hold the value w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fb_addsub_unit.sv
// N-bit ripple-carry adder/subtractor built from full adders.
// sub=1 inverts b and forces carry-in to 1, so s = a - b and cout=1 means no borrow.
module fb_addsub_unit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0]   c;
  logic [N-1:0] bx;

  assign bx   = b ^ {N{sub}};
  assign c[0] = sub;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/fb_seq_div.sv
// Multi-cycle restoring divider: one trial subtraction per clock.
// Handshake: start is accepted only in IDLE or DONE; busy is high during the
// WIDTH CALC cycles; done pulses for one cycle when quotient/remainder/div_by_zero
// are updated, and those results hold until the next accepted start.
// Optional build macro FB_DIV_SIGNED_EN selects two's-complement operands.
module fb_seq_div
  import fb_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state;
  logic [WIDTH:0]   a_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   trial;
  logic             trial_cout;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;

  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] fin_q;
  logic [WIDTH-1:0] fin_r;

  // Left shift of {A,Q}: the top bit of Q moves into the bottom of A.
  assign a_sh = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};

  fb_addsub_unit #(.N(WIDTH + 1)) u_trial (
    .a    (a_sh),
    .b    ({1'b0, d_reg}),
    .sub  (1'b1),
    .s    (trial),
    .cout (trial_cout)
  );

  // No borrow: keep the difference and record a 1 quotient bit.
  assign a_step = trial_cout ? trial : a_sh;
  assign q_step = {q_reg[WIDTH-2:0], trial_cout};

`ifdef FB_DIV_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] neg0_in;
  logic [WIDTH-1:0] neg1_in;
  logic [WIDTH-1:0] neg0_out;
  logic [WIDTH-1:0] neg1_out;
  logic             neg0_cout_unused;
  logic             neg1_cout_unused;

  // The negators take magnitudes at accept time and sign-correct on the last
  // CALC step; those never coincide, so the inputs are muxed on state.
  assign neg0_in = (state == CALC) ? q_step : dividend;
  assign neg1_in = (state == CALC) ? a_step[WIDTH-1:0] : divisor;

  fb_addsub_unit #(.N(WIDTH)) u_neg0 (
    .a    ('0),
    .b    (neg0_in),
    .sub  (1'b1),
    .s    (neg0_out),
    .cout (neg0_cout_unused)
  );

  fb_addsub_unit #(.N(WIDTH)) u_neg1 (
    .a    ('0),
    .b    (neg1_in),
    .sub  (1'b1),
    .s    (neg1_out),
    .cout (neg1_cout_unused)
  );

  assign dvd_mag = dividend[WIDTH-1] ? neg0_out : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? neg1_out : divisor;
  assign fin_q   = neg_q ? neg0_out : q_step;
  assign fin_r   = neg_r ? neg1_out : a_step[WIDTH-1:0];

  // Result sign flags captured when a non-zero divide is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start && (state != CALC) && (divisor != '0)) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign fin_q   = q_step;
  assign fin_r   = a_step[WIDTH-1:0];
`endif

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              d_reg <= dvs_mag;
              a_reg <= '0;
              q_reg <= dvd_mag;
              cnt   <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          a_reg <= a_step;
          q_reg <= q_step;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            quotient    <= fin_q;
            remainder   <= fin_r;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == CALC);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_fb_seq_div.sv
// Randomized self-checking bench for fb_seq_div with directed corner cases.
// Expected results come from integer division in a reference function and
// are queued at start; a monitor pops one entry per done pulse.
module tb_fb_seq_div;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  logic [2*W:0] exp_q[$];
  logic [2*W:0] last_exp;
  logic [2*W:0] mon_e;
  int           checks;
  int           errors;
  int           pushed;
  int           done_seen;

  fb_seq_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: {div_by_zero, remainder, quotient} from plain integer division.
  function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] q;
    logic [W-1:0] r;
    int sx;
    int sy;
    int iq;
    int ir;
    if (y == '0) return {1'b1, x, {W{1'b1}}};
`ifdef FB_DIV_SIGNED_EN
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    iq = sx / sy;
    ir = sx % sy;
    q  = iq[W-1:0];
    r  = ir[W-1:0];
`else
    sx = int'(x);
    sy = int'(y);
    iq = sx / sy;
    ir = sx % sy;
    q  = iq[W-1:0];
    r  = ir[W-1:0];
`endif
    return {1'b0, r, q};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        done_seen++;
        check("quotient", 32'(quotient), 32'(mon_e[W-1:0]));
        check("remainder", 32'(remainder), 32'(mon_e[2*W-1:W]));
        check("div_by_zero", 32'(div_by_zero), 32'(mon_e[2*W]));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_quotient"}, 32'(quotient), 32'd0);
    check({tag, "_remainder"}, 32'(remainder), 32'd0);
    check({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Driver: called at a negedge; returns at the negedge where done is seen.
  // mode 0: operands scrambled during CALC; mode 1: also stray start pulses
  // (14/7 on the 2nd CALC cycle); mode 2: reset asserted on the 2nd CALC cycle.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
    int cyc;
    int busy_n;
    int lat;
    start    = 1'b1;
    dividend = x;
    divisor  = y;
    if (mode != 2) begin
      last_exp = model(x, y);
      exp_q.push_back(last_exp);
      pushed++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc    = 1;
    busy_n = 0;
    lat    = (y == '0) ? 1 : W + 1;
    while (!done && cyc <= 3 * W) begin
      busy_n += int'(busy);
      if (mode == 2 && cyc == 2) begin
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", 32'(done), 32'd0);
        end
        return;
      end
      if (mode == 1 && cyc == 2) begin
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd7;
      end else begin
        start    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        dividend = W'($urandom_range(0, (1 << W) - 1));
        divisor  = W'($urandom_range(0, (1 << W) - 1));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("busy_cycles", 32'(busy_n), (y == '0) ? 32'd0 : 32'(W));
  endtask

  // Idle gap after an operation: done must have dropped, results must hold.
  task automatic gap_check();
    @(negedge clk);
    check("done_pulse_width", 32'(done), 32'd0);
    check("hold_quotient", 32'(quotient), 32'(last_exp[W-1:0]));
    check("hold_remainder", 32'(remainder), 32'(last_exp[2*W-1:W]));
  endtask

  // Main sequence: reset, directed cases, then randomized traffic.
  initial begin
    checks    = 0;
    errors    = 0;
    pushed    = 0;
    done_seen = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'd13, 4'd3, 0);
    gap_check();
    do_op(4'd7, 4'd0, 0);
    gap_check();
    do_op(4'd15, 4'd1, 0);
    do_op(4'd3, 4'd4, 0);
    gap_check();
    do_op(4'd9, 4'd2, 1);
    gap_check();
    do_op(4'd12, 4'd5, 2);
    @(negedge clk);
`ifdef FB_DIV_SIGNED_EN
    do_op(4'b1001, 4'b0010, 0);
    gap_check();
    do_op(4'b1000, 4'b1111, 0);
    gap_check();
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom_range(0, (1 << W) - 1));
      y = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, (1 << W) - 1));
      do_op(x, y, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) gap_check();
    end

    repeat (3) @(negedge clk);
    check("done_count", 32'(done_seen), 32'(pushed));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
